// File: rtl/aes_key_exp_ctrl.sv
// AES-128 key-expansion sequencer. Steers the expansion datapath through
// round keys 0..ROUNDS and hands each one to the round pipeline over a
// valid/ready handshake. The expansion only advances when a key is accepted.
module aes_key_exp_ctrl #(
    parameter int unsigned ROUNDS   = 10,
    parameter int unsigned RC_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        key_MUX1,
    output logic                        key_MUX2,
    output logic [$clog2(RC_WIDTH)-1:0] RC_sig,
    output logic                        FF1_enable,
    output logic                        rk_valid,
    input  logic                        rk_ready,
    output logic [3:0]                  rk_round,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned RC_W = $clog2(RC_WIDTH);
    localparam logic [3:0]  LAST = 4'(ROUNDS);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPresent,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] round_cnt_q, round_cnt_d;

    // Counter sanity: values above LAST are unreachable and treated as a fault.
    logic cnt_ok;
    logic transfer;

    assign cnt_ok   = (round_cnt_q <= LAST);
    assign transfer = (state_q == StPresent) && cnt_ok && rk_ready;

    // State and round counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            round_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    // Next-state and counter update; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                round_cnt_d = 4'd0;
                state_d     = StPresent;
            end
            StPresent: begin
                if (!cnt_ok) begin
                    state_d     = StIdle;
                    round_cnt_d = 4'd0;
                end else if (transfer) begin
                    if (round_cnt_q < LAST) begin
                        round_cnt_d = round_cnt_q + 4'd1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d     = StIdle;
                round_cnt_d = 4'd0;
            end
            default: begin
                state_d     = StIdle;
                round_cnt_d = 4'd0;
            end
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            round_cnt_d = 4'd0;
        end
    end

    // Datapath steering and handshake outputs, decoded from the current state.
    always_comb begin
        key_MUX1   = 1'b0;
        key_MUX2   = 1'b0;
        RC_sig     = '0;
        FF1_enable = 1'b0;
        rk_valid   = 1'b0;
        rk_round   = 4'd0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
            end
            StLoad: begin
                key_MUX1   = 1'b1;
                FF1_enable = !abort;
                busy       = 1'b1;
            end
            StPresent: begin
                busy     = 1'b1;
                rk_valid = cnt_ok;
                rk_round = round_cnt_q;
                RC_sig   = RC_W'(round_cnt_q);
                key_MUX2 = (round_cnt_q != 4'd0);
                // Load the next key only on an accepted, non-final, non-aborted transfer.
                FF1_enable = transfer && !abort && (round_cnt_q < LAST);
            end
            StDone: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aes_key_exp_ctrl.sv
// Bench for aes_key_exp_ctrl: a behavioural key-expansion datapath follows the
// controller's steering outputs, and every accepted key is checked against a
// scoreboard of FIPS-197 A.1 round keys.
module tb_aes_key_exp_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         key_MUX1;
    logic         key_MUX2;
    logic [3:0]   RC_sig;
    logic         FF1_enable;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    logic [127:0] key_vector;
    logic [127:0] rk_reg;
    logic [127:0] round_key;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int fcnt   = 0;
    int dcnt   = 0;

    typedef struct packed {
        logic [3:0]   round;
        logic [127:0] key;
    } exp_t;

    exp_t sb[$];

    aes_key_exp_ctrl #(
        .ROUNDS  (10),
        .RC_WIDTH(10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .key_MUX1  (key_MUX1),
        .key_MUX2  (key_MUX2),
        .RC_sig    (RC_sig),
        .FF1_enable(FF1_enable),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_round  (rk_round),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ---------------- AES key-expansion reference functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] b;
        logic [7:0] s = 8'h63;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        b = inv;
        for (int k = 0; k < 5; k++) begin
            s = s ^ b;
            b = {b[6:0], b[7]};
        end
        return s;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r = 8'h01;
        for (int j = 0; j < int'(idx); j++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] idx);
        logic [31:0] w0 = k[127:96];
        logic [31:0] w1 = k[95:64];
        logic [31:0] w2 = k[63:32];
        logic [31:0] w3 = k[31:0];
        logic [31:0] t;
        t = {w3[23:0], w3[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {rcon(idx), 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] fips_key(input int r);
        case (r)
            0:  return 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
            1:  return 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
            2:  return 128'hf2c295f2_7a96b943_5935807a_7359f67f;
            3:  return 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
            4:  return 128'hef44a541_a8525b7f_b671253b_db0bad00;
            5:  return 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
            6:  return 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
            7:  return 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
            8:  return 128'head27321_b58dbad2_312bf560_7f8d292f;
            9:  return 128'hac7766f3_19fadc21_28d12941_575c006e;
            default: return 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
        endcase
    endfunction

    // Behavioural expansion datapath driven by the controller's steering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_reg <= '0;
        end else if (FF1_enable) begin
            rk_reg <= key_MUX1 ? key_vector : expand(rk_reg, RC_sig);
        end
    end

    assign round_key = key_MUX2 ? rk_reg : key_vector;

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_all();
        for (int r = 0; r <= 10; r++) sb.push_back('{round: 4'(r), key: fips_key(r)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, input int mode);
        bit seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            rk_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("done_seen", 128'(seen), 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (rk_valid && rk_round == r) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("reach_round", 128'(seen), 128'd1);
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every accepted transfer.
    initial begin
        bit   stalled_prev = 1'b0;
        logic [3:0] held_round = 4'd0;
        bit   xfer;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                xfer = rk_valid && rk_ready && !abort;
                if (!rk_valid) check("mux2_not_present", 128'(key_MUX2), 128'd0);
                if (rk_valid && !xfer) check("ff1_no_xfer", 128'(FF1_enable), 128'd0);
                if (stalled_prev && rk_valid) check("hold_round", 128'(rk_round), 128'(held_round));
                if (xfer) begin
                    if (sb.size() == 0) begin
                        check("unexpected_xfer", 128'd1, 128'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rk_round", 128'(rk_round), 128'(e.round));
                        check("rc_sig", 128'(RC_sig), 128'(e.round));
                        check("mux2", 128'(key_MUX2), 128'(e.round != 4'd0));
                        check("round_key", round_key, e.key);
                        check("ff1_xfer", 128'(FF1_enable), 128'(e.round < 4'd10));
                    end
                end
                stalled_prev = rk_valid && !rk_ready && !abort;
                held_round   = rk_round;
                if (rk_valid) vcnt++;
                if (rk_valid && FF1_enable) fcnt++;
                if (done) dcnt++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        rk_ready   = 1'b0;
        key_vector = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        repeat (2) step();
        check("reset_outputs",
              128'({key_MUX1, key_MUX2, RC_sig, FF1_enable, rk_valid, rk_round, busy, done}),
              128'd0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_busy", 128'(busy), 128'd0);

        // abort in IDLE is a no-op
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1 check("idle_abort_busy", 128'(busy), 128'd0);

        // Full run, ready held high
        push_all();
        vcnt = 0; fcnt = 0; dcnt = 0;
        start_run();
        #1;
        check("load_mux1", 128'(key_MUX1), 128'd1);
        check("load_ff1", 128'(FF1_enable), 128'd1);
        check("load_busy_valid", 128'({busy, rk_valid, key_MUX2}), 128'b100);
        wait_done(40, 0);
        step();
        check("valid_cycles", 128'(vcnt), 128'd11);
        check("ff1_cycles", 128'(fcnt), 128'd10);
        check("done_pulses", 128'(dcnt), 128'd1);
        check("sb_empty", 128'(sb.size()), 128'd0);
        #1 check("idle_after_done", 128'(busy), 128'd0);

        // start+abort together in IDLE, then back-pressure
        push_all();
        fcnt = 0; dcnt = 0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        #1 check("start_beats_abort", 128'(busy), 128'd1);
        wait_done(120, 1);
        step();
        check("bp_ff1_cycles", 128'(fcnt), 128'd10);
        check("bp_done_pulses", 128'(dcnt), 128'd1);
        check("bp_sb_empty", 128'(sb.size()), 128'd0);

        // Abort on the round-5 transfer
        push_all();
        rk_ready = 1'b1;
        start_run();
        wait_round(4'd5);
        d0 = dcnt;
        abort = 1'b1;
        #1 check("abort_ff1", 128'(FF1_enable), 128'd0);
        step();
        abort = 1'b0;
        #1 check("abort_idle", 128'({busy, rk_valid}), 128'd0);
        sb.delete();
        repeat (3) step();
        check("abort_no_done", 128'(dcnt), 128'(d0));

        // Restart after abort begins again at round 0
        push_all();
        dcnt = 0;
        start_run();
        wait_done(40, 0);
        step();
        check("restart_done", 128'(dcnt), 128'd1);
        check("restart_sb_empty", 128'(sb.size()), 128'd0);

        // start during PRESENT round 3 is ignored
        push_all();
        dcnt = 0;
        start_run();
        wait_round(4'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(40, 0);
        repeat (3) step();
        check("busy_start_done", 128'(dcnt), 128'd1);
        check("busy_start_sb_empty", 128'(sb.size()), 128'd0);

        // Asynchronous reset in the middle of round 7
        push_all();
        start_run();
        wait_round(4'd7);
        #1 rst = 1'b1;
        #1;
        check("async_rst_outputs",
              128'({key_MUX1, key_MUX2, RC_sig, FF1_enable, rk_valid, rk_round, busy, done}),
              128'd0);
        #8 rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", 128'({busy, rk_valid}), 128'd0);
        end

        // Clean run after reset
        push_all();
        dcnt = 0;
        start_run();
        wait_done(40, 0);
        step();
        check("final_done", 128'(dcnt), 128'd1);
        check("final_sb_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_exp_ctrl.md
Name: aes_key_exp_ctrl

Overview:
- Sequencer for the AES-128 key-expansion datapath: drives key_MUX1, key_MUX2, RC_sig and FF1_enable so the datapath yields round keys 0..ROUNDS in order.
- Presents each round key to the cipher-round consumer through a valid/ready handshake, and advances the expansion only when the current key is accepted.
- Sits between the top-level AES controller (start/abort) and the expansion datapath plus round pipeline.

Parameters:
- ROUNDS, 10, number of expanded round keys after the cipher key (AES-128).
- RC_WIDTH, 10, number of round constants; RC_sig width is $clog2(RC_WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin expansion; key_vector is held stable by the parent while busy=1.
- abort  input  1  synchronous abort; the block returns to IDLE.
- key_MUX1  output  1  1 selects key_vector into the round-key register; 0 selects expanded feedback.
- key_MUX2  output  1  round_key source: 0 = key_vector bypass (round 0); 1 = round-key register.
- RC_sig  output  $clog2(RC_WIDTH)  round-constant index used by the datapath to compute the next key.
- FF1_enable  output  1  load strobe for the round-key register.
- rk_valid  output  1  round_key currently holds a valid key.
- rk_ready  input  1  consumer accepts the presented key.
- rk_round  output  4  index 0..ROUNDS of the presented key.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- States: IDLE, LOAD, PRESENT, DONE. The registers are state and round_cnt (4 bits).
- Reset: state=IDLE, round_cnt=0. All outputs are 0: key_MUX1, key_MUX2, RC_sig, FF1_enable, rk_valid, rk_round, busy, done.
- IDLE: outputs are 0. When start=1, the next state is LOAD.
- LOAD (1 cycle): key_MUX1=1, FF1_enable=1, busy=1, rk_valid=0. round_cnt is cleared to 0. Next state is PRESENT.
- PRESENT:
  - rk_valid=1, busy=1, rk_round=round_cnt, RC_sig=round_cnt, key_MUX1=0.
  - key_MUX2=0 when round_cnt==0, otherwise 1.
- Handshake in PRESENT: a transfer occurs when rk_valid & rk_ready.
  - FF1_enable = transfer & (round_cnt<ROUNDS). This is combinational (same cycle) and is 0 otherwise.
  - On a transfer with round_cnt<ROUNDS: round_cnt increments; the state stays PRESENT. The register now captures key round_cnt+1.
  - On a transfer with round_cnt==ROUNDS: there is no load, and the next state is DONE.
  - With no transfer, all outputs hold unchanged. Stalls may last any number of cycles.
- DONE (1 cycle): done=1, busy=1, rk_valid=0. Next state is IDLE.
- Latency: start to the first rk_valid is 2 cycles. With rk_ready held at 1, rk_valid stays high for ROUNDS+1 consecutive cycles, and done follows one cycle after the final transfer.
- start while busy=1 is ignored.
- abort, checked in any non-IDLE state (abort in IDLE has no effect):
  - The next state is IDLE and round_cnt=0.
  - abort has priority over a transfer in the same cycle: FF1_enable is forced to 0 and done is not pulsed.
  - start and abort in the same cycle while in IDLE: start wins, because abort is ignored in IDLE.
- Asynchronous rst mid-operation: all outputs go to their reset values immediately, with no partial load.
- round_cnt never exceeds ROUNDS. Values above ROUNDS are unreachable; if reached, the FSM falls back to IDLE.

Test Plan:
- Reset then start with rk_ready=1 held:
  - The LOAD cycle shows MUX1=1, FF1=1.
  - rk_valid is high for 11 cycles with rk_round 0..10 and RC_sig 0..10.
  - FF1_enable is high in 10 of those cycles, low for round 10.
  - done pulses once; the expanded keys match FIPS-197 Appendix A.1 for key 2b7e1516…09cf4f3c.
- Back-pressure: rk_ready toggles 1,0,0,1,… Each round is held while rk_ready=0, FF1_enable only accompanies accepted transfers, and the final key sequence is unchanged.
- Abort on the round-5 transfer cycle (abort=1, rk_ready=1):
  - FF1_enable=0 and the next state is IDLE.
  - busy=0, done is never asserted.
  - A following start restarts from round 0.
- start pulsed again during PRESENT round 3 is ignored: rk_round continues 3,4,… and there is exactly one done.
- Asynchronous rst asserted mid-round 7, between clock edges: all outputs drop to 0 immediately. After rst deasserts, the block stays IDLE until start.
- key_MUX2 check: 0 only while rk_round=0, 1 for rounds 1..10, 0 in IDLE, LOAD and DONE.
